// File: rtl/fp_exception_unit_pkg.sv
// fp_exception_unit_pkg: shared op/exception codes, operand class record and decode helpers
package fp_exception_unit_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fp_op_e;

    typedef enum logic [2:0] {
        EXC_NO       = 3'b000,
        EXC_QNAN     = 3'b001,
        EXC_SNAN     = 3'b010,
        EXC_INF      = 3'b011,
        EXC_ZERO_DIV = 3'b100
    } exce_e;

    localparam int STK_QNAN = 0;
    localparam int STK_SNAN = 1;
    localparam int STK_INF  = 2;
    localparam int STK_DIV0 = 3;

    typedef struct packed {
        logic nan;
        logic qnan;
        logic inf;
        logic zero;
        logic sign;
    } fp_class_t;

    function automatic exce_e decode_exce(fp_op_e op, fp_class_t a, fp_class_t b);
        logic snan, qnan, both_inf, inv;
        snan     = (a.nan && !a.qnan) || (b.nan && !b.qnan);
        qnan     = a.qnan || b.qnan;
        both_inf = a.inf && b.inf;
        inv      = op == OP_ADD ? both_inf && (a.sign != b.sign) :
                   op == OP_SUB ? both_inf && (a.sign == b.sign) :
                   op == OP_MUL ? (a.zero && b.inf) || (a.inf && b.zero) :
                   both_inf;
        return snan ? EXC_SNAN :
               qnan ? EXC_QNAN :
               inv  ? EXC_INF  :
               (op == OP_DIV && b.zero) ? EXC_ZERO_DIV : EXC_NO;
    endfunction

    function automatic logic [3:0] sticky_bit(exce_e e);
        return e == EXC_QNAN     ? 4'b1 << STK_QNAN :
               e == EXC_SNAN     ? 4'b1 << STK_SNAN :
               e == EXC_INF      ? 4'b1 << STK_INF  :
               e == EXC_ZERO_DIV ? 4'b1 << STK_DIV0 : 4'b0;
    endfunction

endpackage

// File: rtl/fp_exception_unit_if.sv
// fp_exception_unit_if: request/result stream and sticky status bundle
interface fp_exception_unit_if
    import fp_exception_unit_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       fp_operation;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             out_valid;
    logic             out_ready;
    logic             op_is_exception;
    exce_e            fp_exce;
    logic             sticky_clr;
    logic [3:0]       sticky_flags;
    logic [CNT_W-1:0] exce_count;

    modport master (
        output in_valid, fp_operation, op_a, op_b, out_ready, sticky_clr,
        input  in_ready, out_valid, op_is_exception, fp_exce, sticky_flags, exce_count
    );
    modport slave (
        input  in_valid, fp_operation, op_a, op_b, out_ready, sticky_clr,
        output in_ready, out_valid, op_is_exception, fp_exce, sticky_flags, exce_count
    );
endinterface

// File: rtl/fp_exception_unit_classify.sv
// fp_classify: IEEE-style class bits of one {sign, exp, man} operand
module fp_classify #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 is_nan,
    output logic                 is_qnan,
    output logic                 is_inf,
    output logic                 is_zero,
    output logic                 sign
);
    logic exp_ones, man_zero;
    assign exp_ones = &op[MAN_W +: EXP_W];
    assign man_zero = ~|op[MAN_W-1:0];
    assign is_nan   = exp_ones && !man_zero;
    assign is_qnan  = is_nan && op[MAN_W-1];
    assign is_inf   = exp_ones && man_zero;
    // denormals have a nonzero mantissa, so they never count as zero
    assign is_zero  = ~|op[EXP_W+MAN_W-1:0];
    assign sign     = op[EXP_W+MAN_W];
endmodule

// File: rtl/fp_exception_unit.sv
// fp_exception_unit: two-stage elastic exception classifier with sticky flags and saturating counter
module fp_exception_unit
    import fp_exception_unit_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    fp_exception_unit_if.slave bus
);
    fp_class_t        cls_a, cls_b, s1_a, s1_b;
    fp_op_e           s1_op;
    logic             s1_valid, s2_valid, s1_load, s2_load, fire;
    exce_e            s2_exce;
    logic [3:0]       flags, flags_n;
    logic [CNT_W-1:0] count, count_base, count_n;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op(bus.op_a), .is_nan(cls_a.nan), .is_qnan(cls_a.qnan),
        .is_inf(cls_a.inf), .is_zero(cls_a.zero), .sign(cls_a.sign)
    );
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op(bus.op_b), .is_nan(cls_b.nan), .is_qnan(cls_b.qnan),
        .is_inf(cls_b.inf), .is_zero(cls_b.zero), .sign(cls_b.sign)
    );

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;

    // a clear in the same cycle as a recorded exception is applied first
    always_comb begin
        fire       = s2_valid && bus.out_ready && (s2_exce != EXC_NO);
        count_base = bus.sticky_clr ? '0 : count;
        flags_n    = (bus.sticky_clr ? 4'b0 : flags) | (fire ? sticky_bit(s2_exce) : 4'b0);
        count_n    = (fire && !(&count_base)) ? count_base + 1'b1 : count_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_exce  <= EXC_NO;
            flags    <= '0;
            count    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                s1_op    <= fp_op_e'(bus.fp_operation);
                s1_a     <= cls_a;
                s1_b     <= cls_b;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                s2_exce  <= s1_valid ? decode_exce(s1_op, s1_a, s1_b) : EXC_NO;
            end
            flags <= flags_n;
            count <= count_n;
        end
    end

    assign bus.in_ready        = s1_load;
    assign bus.out_valid       = s2_valid;
    assign bus.fp_exce         = s2_exce;
    assign bus.op_is_exception = s2_exce != EXC_NO;
    assign bus.sticky_flags    = flags;
    assign bus.exce_count      = count;
endmodule

// File: tb/tb_fp_exception_unit.sv
// tb_fp_exception_unit: directed checks of classification, backpressure, sticky/counter and reset
module tb_fp_exception_unit;
    import fp_exception_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    fp_exception_unit_if #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) bus ();
    fp_exception_unit #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [2:0] exce, output logic isx, output int lat);
        bus.in_valid = 1'b1;
        bus.fp_operation = op;
        bus.op_a = a;
        bus.op_b = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        exce = 'x;
        isx = 'x;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                exce = bus.fp_exce;
                isx = bus.op_is_exception;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.fp_operation = 0; bus.op_a = 0; bus.op_b = 0;
        bus.out_ready = 1; bus.sticky_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); else passed++;
        total++; if (bus.fp_exce !== 3'b000) $display("FAIL rst_fp_exce: got %b exp 000", bus.fp_exce); else passed++;
        total++; if (bus.op_is_exception !== 1'b0) $display("FAIL rst_isx: got %b exp 0", bus.op_is_exception); else passed++;
        total++; if (bus.sticky_flags !== 4'b0) $display("FAIL rst_flags: got %b exp 0000", bus.sticky_flags); else passed++;
        total++; if (bus.exce_count !== 8'd0) $display("FAIL rst_count: got %0d exp 0", bus.exce_count); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); else passed++;
    endtask

    task automatic test_nan();
        logic [2:0] e; logic x; int lat;
        @(negedge clk);
        issue(OP_ADD, 8'h38, 8'h79, e, x, lat);
        total++; if (e !== 3'b010) $display("FAIL add_1_snan: got %b exp 010", e); else passed++;
        total++; if (lat !== 2) $display("FAIL latency: got %0d exp 2", lat); else passed++;
        issue(OP_ADD, 8'h7C, 8'h79, e, x, lat);
        total++; if (e !== 3'b010) $display("FAIL add_qnan_snan: got %b exp 010", e); else passed++;
        @(posedge clk); #1;
        total++; if (bus.sticky_flags !== 4'b0010) $display("FAIL flags_snan: got %b exp 0010", bus.sticky_flags); else passed++;
        @(negedge clk);
        issue(OP_ADD, 8'h7C, 8'h38, e, x, lat);
        total++; if (e !== 3'b001) $display("FAIL add_qnan: got %b exp 001", e); else passed++;
        total++; if (x !== 1'b1) $display("FAIL add_qnan_isx: got %b exp 1", x); else passed++;
        @(posedge clk); #1;
        total++; if (bus.sticky_flags !== 4'b0011) $display("FAIL flags_qnan: got %b exp 0011", bus.sticky_flags); else passed++;
        total++; if (bus.exce_count !== 8'd3) $display("FAIL count_3: got %0d exp 3", bus.exce_count); else passed++;
    endtask

    task automatic test_inf();
        logic [2:0] e; logic x; int lat;
        @(negedge clk);
        issue(OP_SUB, 8'hF8, 8'hF8, e, x, lat);
        total++; if (e !== 3'b011) $display("FAIL sub_ninf_ninf: got %b exp 011", e); else passed++;
        issue(OP_SUB, 8'h78, 8'hF8, e, x, lat);
        total++; if (e !== 3'b000) $display("FAIL sub_pinf_ninf: got %b exp 000", e); else passed++;
        issue(OP_ADD, 8'h78, 8'hF8, e, x, lat);
        total++; if (e !== 3'b011) $display("FAIL add_pinf_ninf: got %b exp 011", e); else passed++;
        issue(OP_ADD, 8'h78, 8'h78, e, x, lat);
        total++; if (e !== 3'b000) $display("FAIL add_pinf_pinf: got %b exp 000", e); else passed++;
        total++; if (x !== 1'b0) $display("FAIL add_pinf_pinf_isx: got %b exp 0", x); else passed++;
    endtask

    task automatic test_muldiv();
        logic [2:0] e; logic x; int lat;
        @(negedge clk);
        issue(OP_MUL, 8'h00, 8'hF8, e, x, lat);
        total++; if (e !== 3'b011) $display("FAIL mul_zero_inf: got %b exp 011", e); else passed++;
        issue(OP_MUL, 8'hF8, 8'h80, e, x, lat);
        total++; if (e !== 3'b011) $display("FAIL mul_inf_nzero: got %b exp 011", e); else passed++;
        issue(OP_MUL, 8'h38, 8'h78, e, x, lat);
        total++; if (e !== 3'b000) $display("FAIL mul_one_inf: got %b exp 000", e); else passed++;
        issue(OP_DIV, 8'h38, 8'h80, e, x, lat);
        total++; if (e !== 3'b100) $display("FAIL div_by_nzero: got %b exp 100", e); else passed++;
        issue(OP_DIV, 8'h78, 8'h78, e, x, lat);
        total++; if (e !== 3'b011) $display("FAIL div_inf_inf: got %b exp 011", e); else passed++;
        issue(OP_DIV, 8'h00, 8'h00, e, x, lat);
        total++; if (e !== 3'b100) $display("FAIL div_zero_zero: got %b exp 100", e); else passed++;
        issue(OP_DIV, 8'h38, 8'h01, e, x, lat);
        total++; if (e !== 3'b000) $display("FAIL div_by_denorm: got %b exp 000", e); else passed++;
        issue(OP_DIV, 8'h79, 8'h00, e, x, lat);
        total++; if (e !== 3'b010) $display("FAIL div_snan_zero: got %b exp 010", e); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_DIV};
        logic [7:0] as [4] = '{8'h38, 8'h7C, 8'hF8, 8'h38};
        logic [7:0] bs [4] = '{8'h79, 8'h38, 8'hF8, 8'h00};
        logic [2:0] exps [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        int sent = 0, got = 0, stall_left = 0;
        bit stall_done = 0;
        logic hs_in, hs_out;
        @(negedge clk);
        bus.out_ready = 1; bus.in_valid = 1;
        bus.fp_operation = ops[0]; bus.op_a = as[0]; bus.op_b = bs[0];
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (bus.out_valid && !stall_done) begin
                bus.out_ready = 0; stall_left = 3; stall_done = 1;
            end else if (stall_left == 0) bus.out_ready = 1;
            #1;
            hs_in = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            if (stall_left == 3) begin
                total++; if (sent !== 2) $display("FAIL b2b_accepted_before_stall: got %0d exp 2", sent); else passed++;
            end
            if (stall_left > 0) begin
                total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_in_ready_stall: got %b exp 0", bus.in_ready); else passed++;
                stall_left--;
            end
            if (bus.out_valid) begin
                total++; if (bus.fp_exce !== exps[got]) $display("FAIL b2b_result_%0d: got %b exp %b", got, bus.fp_exce, exps[got]); else passed++;
            end
            @(posedge clk); #1;
            if (hs_in) begin
                sent++;
                if (sent < 4) begin
                    bus.fp_operation = ops[sent]; bus.op_a = as[sent]; bus.op_b = bs[sent];
                end else bus.in_valid = 0;
            end
            if (hs_out) got++;
            @(negedge clk);
        end
        bus.out_ready = 1;
        total++; if (got !== 4) $display("FAIL b2b_results_delivered: got %0d exp 4", got); else passed++;
        repeat (2) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_no_duplicate: got %b exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_saturation();
        int delivered = 0;
        @(negedge clk);
        bus.sticky_clr = 1;
        @(posedge clk); #1 bus.sticky_clr = 0;
        bus.out_ready = 1; bus.in_valid = 1;
        bus.fp_operation = OP_ADD; bus.op_a = 8'h79; bus.op_b = 8'h00;
        for (int i = 0; i < 310; i++) begin
            @(negedge clk);
            if (i == 100) begin
                total++; if (bus.exce_count !== delivered[7:0]) $display("FAIL count_tracking: got %0d exp %0d", bus.exce_count, delivered); else passed++;
            end
            if (bus.out_valid && bus.out_ready && bus.op_is_exception) delivered++;
        end
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready && bus.op_is_exception) delivered++;
        end
        total++; if (delivered < 300) $display("FAIL sat_throughput: got %0d exp >=300", delivered); else passed++;
        total++; if (bus.exce_count !== 8'd255) $display("FAIL count_saturate: got %0d exp 255", bus.exce_count); else passed++;
        total++; if (bus.sticky_flags !== 4'b0010) $display("FAIL sat_flags: got %b exp 0010", bus.sticky_flags); else passed++;
    endtask

    task automatic test_clear();
        logic [2:0] e; logic x; int lat;
        @(negedge clk);
        bus.sticky_clr = 1;
        @(posedge clk); #1 bus.sticky_clr = 0;
        total++; if (bus.sticky_flags !== 4'b0) $display("FAIL clr_flags: got %b exp 0000", bus.sticky_flags); else passed++;
        total++; if (bus.exce_count !== 8'd0) $display("FAIL clr_count: got %0d exp 0", bus.exce_count); else passed++;
        @(negedge clk);
        issue(OP_DIV, 8'h38, 8'h00, e, x, lat);
        total++; if (e !== 3'b100) $display("FAIL clr_div0_code: got %b exp 100", e); else passed++;
        bus.sticky_clr = 1;
        @(posedge clk); #1 bus.sticky_clr = 0;
        total++; if (bus.sticky_flags !== 4'b1000) $display("FAIL clr_coincident_flags: got %b exp 1000", bus.sticky_flags); else passed++;
        total++; if (bus.exce_count !== 8'd1) $display("FAIL clr_coincident_count: got %0d exp 1", bus.exce_count); else passed++;
    endtask

    task automatic test_mid_reset();
        bit stale = 0;
        @(negedge clk);
        bus.out_ready = 0; bus.in_valid = 1;
        bus.fp_operation = OP_DIV; bus.op_a = 8'h38; bus.op_b = 8'h00;
        @(posedge clk); #1;
        bus.fp_operation = OP_MUL; bus.op_a = 8'h00; bus.op_b = 8'h78;
        @(posedge clk); #1 bus.in_valid = 0;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL inflight_valid: got %b exp 1", bus.out_valid); else passed++;
        rst_n = 0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b exp 0", bus.out_valid); else passed++;
        total++; if (bus.fp_exce !== 3'b000) $display("FAIL mrst_fp_exce: got %b exp 000", bus.fp_exce); else passed++;
        total++; if (bus.op_is_exception !== 1'b0) $display("FAIL mrst_isx: got %b exp 0", bus.op_is_exception); else passed++;
        total++; if (bus.sticky_flags !== 4'b0) $display("FAIL mrst_flags: got %b exp 0000", bus.sticky_flags); else passed++;
        total++; if (bus.exce_count !== 8'd0) $display("FAIL mrst_count: got %0d exp 0", bus.exce_count); else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1; bus.out_ready = 1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mrst_in_ready: got %b exp 1", bus.in_ready); else passed++;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1;
        end
        total++; if (stale !== 1'b0) $display("FAIL mrst_stale_result: got %b exp 0", stale); else passed++;
    endtask

    initial begin
        test_reset();
        test_nan();
        test_inf();
        test_muldiv();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fp_exception_unit.md
# fp_exception_unit

Parametrised, pipelined IEEE-style exception classifier for the FPU datapath, succeeding the combinational 8-bit exception checker. It classifies both operands of an add/sub/mul/div request, reports the exception code two cycles later over a valid/ready stream, and maintains sticky status flags and a saturating exception counter for software. It sits beside the arithmetic pipeline; its result stream is consumed by the FPU result mux.

## Interface
Parameters:
- EXP_W, 4, exponent field width
- MAN_W, 3, mantissa field width; operand width W = 1+EXP_W+MAN_W (default 8)
- CNT_W, 8, exception counter width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  request valid
- IN_READY  out  1  request accepted when IN_VALID && IN_READY
- FP_OPERATION  in  2  00 add, 01 sub, 10 mul, 11 div
- OP_A, OP_B  in  W  operands {sign, exp, man}
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  downstream accepts result
- OP_IS_EXCEPTION  out  1  result is exceptional
- FP_EXCE  out  3  exception code
- STICKY_CLR  in  1  clear sticky flags and counter
- STICKY_FLAGS  out  4  {div0, invalid_inf, snan, qnan}, bit 3..0
- EXCE_COUNT  out  CNT_W  exceptional results delivered, saturating

## Operation
- Classification per operand: NaN = exp all ones, man ≠ 0; quiet if man MSB = 1, else signalling. Inf = exp all ones, man = 0. Zero = exp 0, man 0, either sign. Denormals are not zero.
- Codes: NO=000, qNAN=001, sNAN=010, INF (invalid)=011, ZERO_DIV=100.
- Priority, all ops: any sNaN operand (A or B) -> sNAN; else any qNaN -> qNAN; else op-specific rule; else NO.
- Op rules: add: inf operands of opposite sign -> INF. sub: inf operands of equal sign -> INF (+inf−+inf and −inf−−inf). mul: zero×inf either order -> INF. div: inf/inf -> INF; else B zero -> ZERO_DIV (includes 0/0).
- OP_IS_EXCEPTION = (FP_EXCE ≠ NO).
- Sticky/counter update only on output handshake (OUT_VALID && OUT_READY) with exception; flag bit set per code; counter +1, holds at 2^CNT_W−1.
- STICKY_CLR: flags/counter cleared; if a handshake with exception occurs the same cycle, that event is recorded after the clear (flag set, counter = 1).

## Timing
- Two register stages: S1 holds operand class bits + op; S2 holds FP_EXCE/OP_IS_EXCEPTION. Latency 2 cycles from input handshake to OUT_VALID with OUT_READY high; throughput 1/cycle.
- S2 loads when !S2_valid || OUT_READY. S1 loads when !S1_valid || S2 loads. IN_READY = S1 load condition (combinational path from OUT_READY permitted; no skid buffer).
- Under backpressure, OUT_VALID and payload hold stable until accepted; no result dropped or duplicated; max 2 requests in flight.
- Reset (any time, incl. mid-stream): both stages emptied, OUT_VALID=0, OP_IS_EXCEPTION=0, FP_EXCE=000, STICKY_FLAGS=0, EXCE_COUNT=0; IN_READY=1 after reset deasserts. In-flight requests are discarded.

## Structure
- FPU_PACK gains: op codes, exception codes, sticky bit indices; existing `_ADDITION.. and `_*_EXCE macros reused with these values.
- Sub-module fp_classify (params EXP_W, MAN_W; outputs is_nan, is_qnan, is_inf, is_zero, sign), instantiated for A and B; replaces the fixed-width per-check modules.
- Top: classification, two-stage elastic pipeline, decode, sticky/counter logic.

## Test plan
(Default widths: +inf 0x78, −inf 0xF8, qNaN 0x7C, sNaN 0x79, +0 0x00, 1.0 0x38.)
- add 0x38+0x79, then add 0x7C+0x79 -> both FP_EXCE=010 at cycle+2; qNaN+1.0 -> 001; flags 0b0010 after first pair.
- sub 0xF8−0xF8 -> 011; add 0x78+0xF8 -> 011; add 0x78+0x78 -> 000, OP_IS_EXCEPTION=0.
- mul 0x00×0xF8 -> 011; div 0x38/0x80 -> 100; div 0x78/0x78 -> 011; div 0x00/0x00 -> 100.
- Back-to-back 4 requests, OUT_READY low 3 cycles after first result -> IN_READY drops after 2 accepted, results emerge in order, payload stable.
- 300 exceptional results with CNT_W=8 -> EXCE_COUNT=255; STICKY_CLR coincident with a div0 handshake -> flags=0b1000, count=1.
- Assert RST_N low with 2 in flight -> OUT_VALID=0, all outputs 0 next edge; no stale result after release.
